// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity type codes and the
// default data width. Used by both the TX and RX sides.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int STATE_WIDTH        = 3;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Parallel-side handshake of the UART transmitter: byte, request, parity
// options going in; busy and frame-complete status coming back.
import uart_pkg::*;

interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_busy;
  logic                  o_done;

  // Producer of bytes (the system side)
  modport master (
    output i_data, i_data_valid, i_par_en, i_par_typ,
    input  o_busy, o_done
  );

  // The transmitter itself
  modport slave (
    input  i_data, i_data_valid, i_par_en, i_par_typ,
    output o_busy, o_done
  );

endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the data word, seeded with 1
// for odd parity so the result is inverted. Shared with the RX checker.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  logic [DATA_WIDTH:0] xor_chain;

  // Seed selects even/odd; each stage folds in one data bit
  assign xor_chain[0] = (par_typ == PAR_ODD);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_xor
      assign xor_chain[gi+1] = xor_chain[gi] ^ data[gi];
    end
  endgenerate

  assign par_bit = xor_chain[DATA_WIDTH];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on the handshake interface and
// serialises start, data (LSB first), optional parity and stop, one bit per
// baud tick. A SYNC state waits for the first tick so every bit is a full
// tick period. All outputs come straight from registers.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_baud_tick,
  uart_tx_ctrl_if.slave       tx_if,
  output logic                o_tx_out,
  output logic                o_cnt_en
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

  tx_state_e             state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_WIDTH-1:0]  bit_idx_reg, bit_idx_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  cnt_en_reg, cnt_en_next;
  logic                  par_bit_calc;

  // Parity is computed from the live inputs and captured on accept
  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (tx_if.i_data),
    .par_typ (tx_if.i_par_typ),
    .par_bit (par_bit_calc)
  );

  // Frame sequencing: next state, datapath updates and next output values
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
    tx_next      = tx_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    cnt_en_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (tx_if.i_data_valid) begin
          shift_next   = tx_if.i_data;
          par_en_next  = tx_if.i_par_en;
          par_bit_next = par_bit_calc;
          busy_next    = 1'b1;
          state_next   = SYNC;
        end
      end
      SYNC: begin
        tx_next = 1'b1;
        if (i_baud_tick) begin
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (i_baud_tick) begin
          tx_next      = shift_reg[0];
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (i_baud_tick) begin
          cnt_en_next = 1'b1;
          shift_next  = shift_reg >> 1;
          if (bit_idx_reg == LAST_IDX) begin
            bit_idx_next = '0;
            if (par_en_reg) begin
              tx_next    = par_bit_reg;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_idx_next = bit_idx_reg + CNT_WIDTH'(1);
            tx_next      = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (i_baud_tick) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (i_baud_tick) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and idles the line
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cnt_en_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      cnt_en_reg  <= cnt_en_next;
    end
  end

  assign o_tx_out     = tx_reg;
  assign o_cnt_en     = cnt_en_reg;
  assign tx_if.o_busy = busy_reg;
  assign tx_if.o_done = done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a table of hand-derived frames, a
// back-to-back sequence, a mid-frame reset and randomized frames, all
// compared against a frame-level reference model.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int DW = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_baud_tick = 1'b0;
  logic o_tx_out;
  logic o_cnt_en;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) tx_if ();

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(3)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_baud_tick (i_baud_tick),
    .tx_if       (tx_if),
    .o_tx_out    (o_tx_out),
    .o_cnt_en    (o_cnt_en)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
  } frame_t;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        pt;
    logic [0:10] bits;   // line value per tick period, start bit first
    int          len;    // ticks from SYNC exit to end of stop
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          viol = 0;
  int          tick_div = 0;
  int          tick_cnt = 0;
  frame_t      exp_q[$];
  logic [15:0] obs_bits = '0;
  int          obs_len = 0;
  int          cnt_en_seen = 0;
  logic        prev_done = 1'b0;
  logic [15:0] last_bits = '0;
  int          last_len = 0;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference: one sample per tick period while busy -- the SYNC wait (line
  // high), start, data LSB first, optional parity, stop.
  function automatic void model_frame(input logic [7:0] d, input logic pe, input logic pt,
                                      output logic [15:0] bits, output int len);
    bits = '0;
    len  = 0;
    bits[len] = 1'b1; len++;
    bits[len] = 1'b0; len++;
    for (int i = 0; i < DW; i++) begin
      bits[len] = d[i]; len++;
    end
    if (pe) begin
      bits[len] = logic'($countones(d) % 2) ^ pt; len++;
    end
    bits[len] = 1'b1; len++;
  endfunction

  // Baud tick generator: one-cycle pulse every tick_div clocks
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (tick_div > 0) begin
        tick_cnt++;
        if (tick_cnt >= tick_div) begin
          i_baud_tick = 1'b1;
          tick_cnt    = 0;
        end else begin
          i_baud_tick = 1'b0;
        end
      end else begin
        i_baud_tick = 1'b0;
      end
    end
  end

  // Monitor: collects the line per tick, checks each completed frame
  initial begin
    logic [15:0] mbits;
    int          mlen;
    frame_t      f;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        obs_len     = 0;
        obs_bits    = '0;
        cnt_en_seen = 0;
        prev_done   = 1'b0;
      end else begin
        if (!tx_if.o_busy && !o_tx_out)  viol++;
        if (!tx_if.o_busy && o_cnt_en)   viol++;
        if (tx_if.o_done && tx_if.o_busy) viol++;
        if (tx_if.o_done && prev_done)   viol++;
        prev_done = tx_if.o_done;
        if (o_cnt_en) cnt_en_seen++;
        if (i_baud_tick && tx_if.o_busy) begin
          if (obs_len < 16) obs_bits[obs_len] = o_tx_out;
          obs_len++;
        end
        if (tx_if.o_done) begin
          check("frame_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            model_frame(f.d, f.pe, f.pt, mbits, mlen);
            $display("[TB] frame data=%02h par_en=%0d par_typ=%0d ticks=%0d cnt_en=%0d",
                     f.d, f.pe, f.pt, obs_len, cnt_en_seen);
            check("frame_len", obs_len, mlen);
            check("frame_bits", 32'(obs_bits), 32'(mbits));
            check("cnt_en_pulses", cnt_en_seen, DW);
          end
          last_bits   = obs_bits;
          last_len    = obs_len;
          obs_len     = 0;
          obs_bits    = '0;
          cnt_en_seen = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input bit hold);
    int n;
    n = 0;
    while (tx_if.o_busy && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    tx_if.i_data       = d;
    tx_if.i_par_en     = pe;
    tx_if.i_par_typ    = pt;
    tx_if.i_data_valid = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!tx_if.o_busy && n < 200);
    check("accept", tx_if.o_busy, 1);
    exp_q.push_back('{d, pe, pt});
    if (!hold) begin
      // Drop the request and disturb the inputs mid-frame
      tx_if.i_data_valid = 1'b0;
      tx_if.i_data       = 8'($urandom);
      tx_if.i_par_en     = 1'($urandom);
      tx_if.i_par_typ    = 1'($urandom);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge i_clk);
      n++;
      if (tx_if.o_done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 1);
    #1;
  endtask

  // Main stimulus
  initial begin
    int          idle_bad;
    int          n;
    logic [0:10] got;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 11'b01010010110, 10};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 11'b01010010101, 11};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 11'b01010010111, 11};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 11'b01110000011, 11};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 11'b00000000011, 11};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 11'b01111111101, 11};
    vecs[6] = '{8'h3C, 1'b0, 1'b0, 11'b00011110010, 10};

    tx_if.i_data       = '0;
    tx_if.i_data_valid = 1'b0;
    tx_if.i_par_en     = 1'b0;
    tx_if.i_par_typ    = 1'b0;
    tick_div           = 4;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_tx_out", o_tx_out, 1);
    check("rst_busy", tx_if.o_busy, 0);
    check("rst_done", tx_if.o_done, 0);
    check("rst_cnt_en", o_cnt_en, 0);
    i_rst = 1'b1;

    // Ticks with no request leave everything idle
    idle_bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_tx_out !== 1'b1 || tx_if.o_busy !== 1'b0 ||
          tx_if.o_done !== 1'b0 || o_cnt_en !== 1'b0) idle_bad++;
    end
    check("idle_ticks", idle_bad, 0);

    // Table of hand-derived frames
    for (int k = 0; k < 7; k++) begin
      send(vecs[k].d, vecs[k].pe, vecs[k].pt, 1'b0);
      wait_done(300);
      got = '0;
      for (int i = 0; i < 11; i++) if (i < last_len - 1) got[i] = last_bits[i+1];
      check($sformatf("vec%0d_len", k), last_len - 1, vecs[k].len);
      check($sformatf("vec%0d_bits", k), 32'(got), 32'(vecs[k].bits));
    end

    // Back-to-back: request held high, data and parity options changed mid-frame
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    tx_if.i_data    = 8'hC3;
    tx_if.i_par_en  = 1'b1;
    tx_if.i_par_typ = 1'b1;
    exp_q.push_back('{8'hC3, 1'b1, 1'b1});
    wait_done(300);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!tx_if.o_busy && n < 10);
    check("b2b_gap_cycles", n, 1);
    tx_if.i_data_valid = 1'b0;
    wait_done(300);

    // Reset during data bit 4, then a clean frame
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (cnt_en_seen < 4 && n < 300) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check("pre_rst_bit4", o_tx_out, 0);
    #2;
    i_rst = 1'b0;
    #1;
    check("rst_async_tx", o_tx_out, 1);
    check("rst_async_busy", tx_if.o_busy, 0);
    exp_q.delete();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    send(8'h5A, 1'b1, 1'b1, 1'b0);
    wait_done(300);

    // Randomized frames at varying baud rates
    repeat (30) begin
      repeat ($urandom_range(0, 5)) @(negedge i_clk);
      tick_div = $urandom_range(2, 6);
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      wait_done(400);
    end

    repeat (10) @(negedge i_clk);
    check("protocol_violations", viol, 0);
    check("pending_frames", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
